// File: rtl/ts_deframer_pkg.sv
// ts_deframer shared types and frame defaults.
// Common to TS_CONTROL, frame source and deframer.
package ts_deframer_pkg;

  localparam int W = 8;
  localparam int CNT_W = 4;
  localparam int DEF_FRAME_SLOTS = 9;
  localparam logic [W-1:0] DEF_SYNC_WORD = 8'hFF;
  localparam int DEF_CONFIRM = 2;
  localparam int DEF_MISS_MAX = 2;

  typedef enum logic [1:0] {
    HUNT,
    CHECK,
    LOCK
  } fsm_state_t;

endpackage

// File: rtl/ts_deframer_if.sv
// Slot stream in, extracted slot and status out.
// master drives the stream, slave is the deframer.
interface ts_deframer_if;
  import ts_deframer_pkg::*;

  logic             sync;
  logic [W-1:0]     ts_data;
  logic [CNT_W-1:0] slot_sel;
  logic [W-1:0]     dout;
  logic             dout_valid;
  logic [CNT_W-1:0] slot_idx;
  logic             locked;
  logic             frame_err;

  modport master (
    output sync, ts_data, slot_sel,
    input  dout, dout_valid, slot_idx,
    input  locked, frame_err
  );

  modport slave (
    input  sync, ts_data, slot_sel,
    output dout, dout_valid, slot_idx,
    output locked, frame_err
  );

endinterface

// File: rtl/ts_deframer_sync_fsm.sv
// Frame alignment hunt/check/lock tracker.
// slot_idx is the index of the slot now on the input.
module ts_deframer_sync_fsm
  import ts_deframer_pkg::*;
#(
  parameter int FRAME_SLOTS = DEF_FRAME_SLOTS,
  parameter int CONFIRM = DEF_CONFIRM,
  parameter int MISS_MAX = DEF_MISS_MAX
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sync_ok,
  output logic             locked,
  output logic             frame_err,
  output logic [CNT_W-1:0] slot_idx
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_SLOTS);
  localparam logic [CNT_W-1:0] CONF = CNT_W'(CONFIRM);
  localparam logic [CNT_W-1:0] MMAX = CNT_W'(MISS_MAX);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  fsm_state_t       state, state_n;
  logic [CNT_W-1:0] slot_cnt, slot_n;
  logic [CNT_W-1:0] good_cnt, good_n;
  logic [CNT_W-1:0] miss_cnt, miss_n;
  logic             ferr_n;
  logic             at_sync;

  assign at_sync = (slot_cnt == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= HUNT;
      slot_cnt  <= '0;
      good_cnt  <= '0;
      miss_cnt  <= '0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      slot_cnt  <= slot_n;
      good_cnt  <= good_n;
      miss_cnt  <= miss_n;
      frame_err <= ferr_n;
    end
  end

  always_comb begin
    state_n = state;
    slot_n  = (slot_cnt == LAST) ? '0 : slot_cnt + ONE;
    good_n  = good_cnt;
    miss_n  = miss_cnt;
    ferr_n  = 1'b0;
    case (state)
      HUNT: begin
        if (sync_ok) begin
          slot_n  = ONE;
          good_n  = ONE;
          miss_n  = '0;
          state_n = (CONFIRM == 1) ? LOCK : CHECK;
        end
      end
      CHECK: begin
        if (at_sync) begin
          if (sync_ok) begin
            good_n = good_cnt + ONE;
            if (good_cnt + ONE >= CONF) begin
              state_n = LOCK;
              miss_n  = '0;
            end
          end else begin
            state_n = HUNT;
          end
        end else if (sync_ok) begin
          slot_n = ONE;
          good_n = ONE;
        end
      end
      LOCK: begin
        if (at_sync) begin
          if (sync_ok) begin
            miss_n = '0;
          end else begin
            ferr_n = 1'b1;
            miss_n = miss_cnt + ONE;
            if (miss_cnt + ONE >= MMAX) begin
              state_n = HUNT;
              miss_n  = '0;
            end
          end
        end else if (sync_ok) begin
          // stray sync while locked: flag only, cadence is trusted
          ferr_n = 1'b1;
        end
      end
      default: state_n = HUNT;
    endcase
  end

  assign locked   = (state == LOCK);
  assign slot_idx = slot_cnt;

endmodule

// File: rtl/ts_deframer.sv
// TDM deframer: alignment tracking plus
// single-slot extraction register.
module ts_deframer
  import ts_deframer_pkg::*;
#(
  parameter int FRAME_SLOTS = DEF_FRAME_SLOTS,
  parameter logic [W-1:0] SYNC_WORD = DEF_SYNC_WORD,
  parameter int CONFIRM = DEF_CONFIRM,
  parameter int MISS_MAX = DEF_MISS_MAX
) (
  input logic         clk,
  input logic         reset,
  ts_deframer_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_SLOTS);

  logic             sync_ok;
  logic             locked;
  logic             frame_err;
  logic [CNT_W-1:0] slot_idx;
  logic             sel_ok;
  logic [W-1:0]     dout_q;
  logic             dv_q;

  assign sync_ok = bus.sync && (bus.ts_data == SYNC_WORD);
  assign sel_ok  = (bus.slot_sel != '0) && (bus.slot_sel <= LAST);

  ts_deframer_sync_fsm #(
    .FRAME_SLOTS(FRAME_SLOTS),
    .CONFIRM(CONFIRM),
    .MISS_MAX(MISS_MAX)
  ) u_fsm (
    .clk(clk),
    .reset(reset),
    .sync_ok(sync_ok),
    .locked(locked),
    .frame_err(frame_err),
    .slot_idx(slot_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      dout_q <= '0;
      dv_q   <= 1'b0;
    end else begin
      dv_q <= 1'b0;
      if (locked && sel_ok && (slot_idx == bus.slot_sel)) begin
        dout_q <= bus.ts_data;
        dv_q   <= 1'b1;
      end
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dv_q;
  assign bus.locked     = locked;
  assign bus.frame_err  = frame_err;
  assign bus.slot_idx   = slot_idx;

endmodule
